// File: rtl/spi_master_trx_if.sv
// spi_master_trx_if: byte request/response handshake and SPI pins for spi_master_trx
interface spi_master_trx_if;
  logic       start;
  logic [7:0] tx_data;
  logic       last;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       spi_cs;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  modport master (input start, tx_data, last, spi_miso, output busy, rx_data, rx_valid, spi_cs, spi_sck, spi_mosi);
  modport slave (output start, tx_data, last, spi_miso, input busy, rx_data, rx_valid, spi_cs, spi_sck, spi_mosi);
endinterface

// File: rtl/spi_master_trx.sv
// spi_master_trx: SPI mode-3 byte master, MSB first, multi-byte frames via last.
// SPI_MASTER_LOOPBACK_EN samples the registered MOSI instead of the MISO pin for board self-test.
module spi_master_trx #(
  parameter int CLK_DIV  = 4,
  parameter int GAP_CLKS = 4
) (
  input logic clk,
  input logic rst,
  spi_master_trx_if.master bus
);
  localparam int CW = $clog2((CLK_DIV > GAP_CLKS ? CLK_DIV : GAP_CLKS) + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP, CS_HOLD, CS_GAP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0] bit_cnt, bit_d;
  logic [7:0] shift_tx, tx_d, shift_rx, srx_d, rx_data, rx_data_d;
  logic high, high_d, last_q, last_d, cs, cs_d, sck, sck_d, mosi, mosi_d;
  logic rx_valid, rx_valid_d, busy, busy_d, sample, div_end, gap_end;
`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample = mosi;
`else
  assign sample = bus.spi_miso;
`endif
  assign div_end = cnt == CW'(CLK_DIV - 1);
  assign gap_end = cnt == CW'(GAP_CLKS - 1);
  assign bus.spi_cs   = cs;
  assign bus.spi_sck  = sck;
  assign bus.spi_mosi = mosi;
  assign bus.busy     = busy;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      high     <= 1'b0;
      shift_tx <= '0;
      shift_rx <= '0;
      rx_data  <= '0;
      last_q   <= 1'b0;
      cs       <= 1'b1;
      sck      <= 1'b1;
      mosi     <= 1'b1;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_cnt  <= bit_d;
      high     <= high_d;
      shift_tx <= tx_d;
      shift_rx <= srx_d;
      rx_data  <= rx_data_d;
      last_q   <= last_d;
      cs       <= cs_d;
      sck      <= sck_d;
      mosi     <= mosi_d;
      rx_valid <= rx_valid_d;
      busy     <= busy_d;
    end
  end
  always_comb begin
    state_d    = state;
    cnt_d      = cnt + 1'b1;
    bit_d      = bit_cnt;
    high_d     = high;
    tx_d       = shift_tx;
    srx_d      = shift_rx;
    rx_data_d  = rx_data;
    last_d     = last_q;
    cs_d       = cs;
    sck_d      = sck;
    mosi_d     = mosi;
    rx_valid_d = 1'b0;
    busy_d     = busy;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = SETUP;
          tx_d    = bus.tx_data;
          last_d  = bus.last;
          cs_d    = 1'b0;
          mosi_d  = bus.tx_data[7];
          busy_d  = 1'b1;
        end
      end
      SETUP: if (div_end) begin
        state_d = SHIFT;
        cnt_d   = '0;
        sck_d   = 1'b0;
        high_d  = 1'b0;
        bit_d   = '0;
      end
      SHIFT: if (div_end) begin
        cnt_d = '0;
        if (!high) begin
          sck_d  = 1'b1;
          high_d = 1'b1;
          srx_d  = {shift_rx[6:0], sample};
        end else if (bit_cnt == 3'd7) begin
          state_d    = DONE;
          rx_data_d  = shift_rx;
          rx_valid_d = 1'b1;
        end else begin
          bit_d  = bit_cnt + 3'd1;
          sck_d  = 1'b0;
          high_d = 1'b0;
          tx_d   = {shift_tx[6:0], 1'b0};
          mosi_d = shift_tx[6];
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = last_q ? CS_HOLD : GAP;
        busy_d  = last_q;
      end
      // GAP waits idle for the next byte, then gives MOSI a half-period of setup before the first fall
      GAP: if (!busy) begin
        cnt_d = '0;
        if (bus.start) begin
          tx_d   = bus.tx_data;
          last_d = bus.last;
          mosi_d = bus.tx_data[7];
          busy_d = 1'b1;
        end
      end else if (div_end) begin
        state_d = SHIFT;
        cnt_d   = '0;
        sck_d   = 1'b0;
        high_d  = 1'b0;
        bit_d   = '0;
      end
      CS_HOLD: if (div_end) begin
        state_d = CS_GAP;
        cnt_d   = '0;
        cs_d    = 1'b1;
        mosi_d  = 1'b1;
      end
      CS_GAP: if (gap_end) begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_master_trx.sv
// tb_spi_master_trx: directed bench for spi_master_trx with a mode-3 slave model on the pins
module tb_spi_master_trx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic miso_r = 1'b1;
  logic [15:0] slave_word = '0;
  logic [15:0] mosi_word = '0;
  int falls = 0, rises = 0, rx_cnt = 0, cs_rises = 0;
  int base_falls = 0, base_rises = 0, base_rx = 0, base_cs = 0;
  int checks = 0, passes = 0, idle_bad = 0;
  spi_master_trx_if bus();
  spi_master_trx #(.CLK_DIV(4), .GAP_CLKS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.spi_miso = miso_r;
  always #5 clk = ~clk;
  always @(negedge bus.spi_sck) if (bus.spi_cs === 1'b0) begin
    int k;
    k = falls - base_falls;
    miso_r = (k >= 0 && k < 16) ? slave_word[4'(15 - k)] : 1'b0;
    falls++;
  end
  always @(posedge bus.spi_sck) if (bus.spi_cs === 1'b0) begin
    mosi_word = {mosi_word[14:0], bus.spi_mosi};
    rises++;
  end
  always @(posedge clk) if (bus.rx_valid === 1'b1) rx_cnt++;
  always @(posedge bus.spi_cs) cs_rises++;
  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] slv);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx;
`else
    return slv;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic snap();
    base_falls = falls;
    base_rises = rises;
    base_rx = rx_cnt;
    base_cs = cs_rises;
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    bus.start = 1'b1;
    bus.tx_data = d;
    bus.last = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_valid(input string tag);
    int t = 0;
    while (bus.rx_valid !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(tag, bus.rx_valid, 1);
  endtask
  task automatic wait_idle(input string tag);
    int t = 0;
    while (!(bus.busy === 1'b0 && bus.spi_cs === 1'b1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, {bus.busy, bus.spi_cs}, 2'b01);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.tx_data = '0;
    bus.last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", bus.spi_cs, 1);
    chk("rst_sck", bus.spi_sck, 1);
    chk("rst_mosi", bus.spi_mosi, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({bus.spi_cs, bus.spi_sck, bus.spi_mosi, bus.busy, bus.rx_valid} !== 5'b11100) idle_bad++;
    end
    chk("idle_stable", idle_bad, 0);
    snap();
    slave_word = 16'h3C00;
    send(8'hA5, 1'b1);
    chk("t1_busy", bus.busy, 1);
    wait_valid("t1_valid");
    chk("t1_rx_data", bus.rx_data, exp_rx(8'hA5, 8'h3C));
    repeat (4) @(negedge clk);
    chk("t1_cs_hold", bus.spi_cs, 0);
    @(negedge clk);
    chk("t1_cs_rise", bus.spi_cs, 1);
    repeat (3) @(negedge clk);
    chk("t1_busy_gap", bus.busy, 1);
    @(negedge clk);
    chk("t1_busy_drop", bus.busy, 0);
    chk("t1_mosi_bits", mosi_word[7:0], 8'hA5);
    chk("t1_falls", falls - base_falls, 8);
    chk("t1_rises", rises - base_rises, 8);
    chk("t1_rx_count", rx_cnt - base_rx, 1);
    snap();
    slave_word = 16'hFF00;
    send(8'h81, 1'b0);
    wait_valid("t2_valid0");
    chk("t2_rx0", bus.rx_data, exp_rx(8'h81, 8'hFF));
    @(negedge clk);
    chk("t2_gap_busy", bus.busy, 0);
    chk("t2_gap_cs", bus.spi_cs, 0);
    send(8'h7E, 1'b1);
    wait_valid("t2_valid1");
    chk("t2_rx1", bus.rx_data, exp_rx(8'h7E, 8'h00));
    chk("t2_cs_low", cs_rises - base_cs, 0);
    wait_idle("t2_idle");
    chk("t2_mosi_bits", mosi_word, 16'h817E);
    chk("t2_falls", falls - base_falls, 16);
    chk("t2_rx_count", rx_cnt - base_rx, 2);
    snap();
    slave_word = 16'h9600;
    send(8'hA5, 1'b1);
    repeat (30) @(negedge clk);
    chk("t3_busy_mid", bus.busy, 1);
    send(8'h55, 1'b1);
    wait_valid("t3_valid");
    chk("t3_rx_data", bus.rx_data, exp_rx(8'hA5, 8'h96));
    wait_idle("t3_idle");
    repeat (20) @(negedge clk);
    chk("t3_still_idle", {bus.busy, bus.spi_cs}, 2'b01);
    chk("t3_mosi_bits", mosi_word[7:0], 8'hA5);
    chk("t3_falls", falls - base_falls, 8);
    chk("t3_rx_count", rx_cnt - base_rx, 1);
    snap();
    slave_word = 16'hC300;
    send(8'hA5, 1'b1);
    begin
      int t = 0;
      while (falls - base_falls < 5 && t < 200) begin
        @(negedge clk);
        t++;
      end
    end
    chk("t4_five_falls", falls - base_falls, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_rst_cs", bus.spi_cs, 1);
    chk("t4_rst_sck", bus.spi_sck, 1);
    chk("t4_rst_busy", bus.busy, 0);
    repeat (100) @(negedge clk);
    chk("t4_no_rx", rx_cnt - base_rx, 0);
    snap();
    slave_word = 16'h5A00;
    send(8'h12, 1'b1);
    wait_valid("t4_valid");
    chk("t4_rx_data", bus.rx_data, exp_rx(8'h12, 8'h5A));
    wait_idle("t4_idle");
    chk("t4_mosi_bits", mosi_word[7:0], 8'h12);
    chk("t4_falls", falls - base_falls, 8);
`ifdef SPI_MASTER_LOOPBACK_EN
    snap();
    slave_word = 16'h0000;
    send(8'hC3, 1'b1);
    wait_valid("lb_valid");
    chk("lb_rx_data", bus.rx_data, 8'hC3);
    wait_idle("lb_idle");
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
